// File: rtl/cache_perf_pkg.sv
// Shared constants and the serving-level encoder for the cache performance monitor.
package cache_perf_pkg;

    localparam int          MAX_LEVELS  = 4;
    localparam int          LVL_IDX_W   = 3;
    localparam int          LAT_W       = 20;
    localparam int          AMAT_FRAC   = 8;
    localparam logic [15:0] DEF_L1_LAT  = 16'd1;
    localparam logic [15:0] DEF_L2_LAT  = 16'd10;
    localparam int          DEF_MEM_LAT = 100;

    // Lowest level whose hit flag is set; num_levels encodes "served by memory".
    function automatic logic [LVL_IDX_W-1:0] serve_level(input logic [MAX_LEVELS-1:0] hit,
                                                         input int num_levels);
        logic [LVL_IDX_W-1:0] s;
        s = LVL_IDX_W'(num_levels);
        for (int i = MAX_LEVELS - 1; i >= 0; i--) begin
            if (i < num_levels && hit[i]) begin
                s = LVL_IDX_W'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with variable increment and synchronous clear.
// Exposes the post-increment value so a snapshot can capture it on the clearing edge.
module perf_sat_counter #(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     cnt_nxt_o,
    output logic             ovf_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    assign sum       = {1'b0, cnt_q} + (W+1)'(inc_i);
    assign ovf_o     = sum[W];
    assign cnt_nxt_o = sum[W] ? '1 : sum[W-1:0];
    assign cnt_d     = clr_i ? '0 : cnt_nxt_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_perf_monitor.sv
// Windowed per-level hit/miss, latency and AMAT monitor for an N-level cache hierarchy.
// Two-stage pipeline (register access, then count); accepts one access per cycle, no backpressure.
module cache_perf_monitor
    import cache_perf_pkg::*;
#(
    parameter int                        NUM_LEVELS = 2,
    parameter int                        CNT_W      = 32,
    parameter int                        CYC_W      = 40,
    parameter int                        WINDOW     = 256,
    parameter logic [16*NUM_LEVELS-1:0]  LEVEL_LAT  = {DEF_L2_LAT, DEF_L1_LAT},
    parameter int                        MEM_LAT    = DEF_MEM_LAT
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  acc_valid,
    input  logic [NUM_LEVELS-1:0]                                 acc_hit,
    input  logic                                                  clear,
    input  logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0] rd_sel,
    output logic [CNT_W-1:0]                                      rd_hits,
    output logic [CNT_W-1:0]                                      rd_misses,
    output logic [CYC_W-1:0]                                      cyc_total,
    output logic [CYC_W-1:0]                                      amat_fx,
    output logic                                                  win_valid,
    output logic                                                  sat
);

    localparam int RD_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int WIN_W = $clog2(WINDOW);

    logic                  s1_vld_q;
    logic [NUM_LEVELS-1:0] s1_hit_q;
    logic [LVL_IDX_W-1:0]  serve;
    logic [LAT_W-1:0]      lat;
    logic [LAT_W-1:0]      cyc_inc;

    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic                  live_sat_q, live_sat_d;
    logic                  win_valid_q, win_valid_d;
    logic                  win_done;
    logic                  live_clr;
    logic                  snap_en;

    logic [NUM_LEVELS-1:0] hit_inc, miss_inc, hit_ovf, miss_ovf;
    logic [CNT_W-1:0]      hit_nxt  [NUM_LEVELS];
    logic [CNT_W-1:0]      miss_nxt [NUM_LEVELS];
    logic [CYC_W-1:0]      cyc_nxt;
    logic                  cyc_ovf;
    logic                  any_ovf;

    logic [CNT_W-1:0]      snap_hits_q [NUM_LEVELS];
    logic [CNT_W-1:0]      snap_miss_q [NUM_LEVELS];
    logic [CYC_W-1:0]      snap_cyc_q;
    logic                  snap_sat_q;

    // Stage 1: a clear also kills whatever access arrives alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_hit_q <= '0;
        end else begin
            s1_vld_q <= acc_valid & ~clear;
            s1_hit_q <= acc_hit;
        end
    end

    assign serve = serve_level(MAX_LEVELS'(s1_hit_q), NUM_LEVELS);

    always_comb begin
        lat = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (LVL_IDX_W'(i) <= serve) begin
                lat = lat + LAT_W'(LEVEL_LAT[16*i +: 16]);
            end
        end
        if (serve == LVL_IDX_W'(NUM_LEVELS)) begin
            lat = lat + LAT_W'(MEM_LAT);
        end
    end

    assign cyc_inc  = s1_vld_q ? lat : '0;
    assign win_done = s1_vld_q & (win_cnt_q == WIN_W'(WINDOW - 1));
    assign live_clr = clear | win_done;
    assign snap_en  = win_done & ~clear;

    // Stage 2: per-level counters; the window-closing access lands in the snapshot, not the live set.
    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lvl
        assign hit_inc[g]  = s1_vld_q & (serve == LVL_IDX_W'(g));
        assign miss_inc[g] = s1_vld_q & (LVL_IDX_W'(g) < serve);

        perf_sat_counter #(.W(CNT_W), .INC_W(1)) u_hits (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (live_clr),
            .inc_i     (hit_inc[g]),
            .cnt_nxt_o (hit_nxt[g]),
            .ovf_o     (hit_ovf[g])
        );

        perf_sat_counter #(.W(CNT_W), .INC_W(1)) u_miss (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (live_clr),
            .inc_i     (miss_inc[g]),
            .cnt_nxt_o (miss_nxt[g]),
            .ovf_o     (miss_ovf[g])
        );
    end

    perf_sat_counter #(.W(CYC_W), .INC_W(LAT_W)) u_cyc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (live_clr),
        .inc_i     (cyc_inc),
        .cnt_nxt_o (cyc_nxt),
        .ovf_o     (cyc_ovf)
    );

    assign any_ovf = (|hit_ovf) | (|miss_ovf) | cyc_ovf;

    always_comb begin
        win_valid_d = snap_en;
        win_cnt_d   = win_cnt_q;
        live_sat_d  = live_sat_q;
        if (clear) begin
            win_cnt_d  = '0;
            live_sat_d = 1'b0;
        end else begin
            if (s1_vld_q) begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
            end
            live_sat_d = win_done ? 1'b0 : (live_sat_q | any_ovf);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q   <= '0;
            live_sat_q  <= 1'b0;
            win_valid_q <= 1'b0;
            snap_cyc_q  <= '0;
            snap_sat_q  <= 1'b0;
            for (int i = 0; i < NUM_LEVELS; i++) begin
                snap_hits_q[i] <= '0;
                snap_miss_q[i] <= '0;
            end
        end else begin
            win_cnt_q   <= win_cnt_d;
            live_sat_q  <= live_sat_d;
            win_valid_q <= win_valid_d;
            if (snap_en) begin
                snap_cyc_q <= cyc_nxt;
                snap_sat_q <= live_sat_q | any_ovf;
                for (int i = 0; i < NUM_LEVELS; i++) begin
                    snap_hits_q[i] <= hit_nxt[i];
                    snap_miss_q[i] <= miss_nxt[i];
                end
            end
        end
    end

    always_comb begin
        rd_hits   = '0;
        rd_misses = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (rd_sel == RD_W'(i)) begin
                rd_hits   = snap_hits_q[i];
                rd_misses = snap_miss_q[i];
            end
        end
    end

    // Q.8 scaling by 1/WINDOW reduces to a shift since WINDOW is a power of two.
    if (WIN_W <= AMAT_FRAC) begin : g_amat_left
        localparam int SH = AMAT_FRAC - WIN_W;
        if (SH == 0) begin : g_none
            assign amat_fx = snap_cyc_q;
        end else begin : g_shl
            assign amat_fx = (|snap_cyc_q[CYC_W-1 -: SH]) ? '1 : (snap_cyc_q << SH);
        end
    end else begin : g_amat_right
        assign amat_fx = snap_cyc_q >> (WIN_W - AMAT_FRAC);
    end

    assign cyc_total = snap_cyc_q;
    assign win_valid = win_valid_q;
    assign sat       = snap_sat_q;

endmodule
